// File: rtl/ultrasonic_echo_capture.sv
// ---------------------------------------------------------------------------
// ultrasonic_echo_capture
//
// Front-end timing stage for an HC-SR04-style ultrasonic ranger. Issues a
// periodic trigger pulse, synchronises the asynchronous echo pin and measures
// the echo high time in raw clock cycles. Results go downstream as a width
// plus a one-cycle valid strobe, or as a one-cycle timeout strobe.
//
// Ports
//   clk          in   system clock (single domain)
//   reset        in   asynchronous active-low reset
//   enable       in   run continuous measurements while high; sampled only
//                     in IDLE and at the last cycle of HOLDOFF
//   echo         in   raw sensor echo pin (asynchronous)
//   trig         out  sensor trigger pulse (registered)
//   pulse_width  out  last measured echo high time, held until next valid
//   pulse_valid  out  one-cycle strobe: pulse_width was updated
//   timeout      out  one-cycle strobe: no complete echo in the window
//   busy         out  high in every state except IDLE
//   state_dbg    out  current FSM state encoding, for observation only
//
// Echo handshake: pulse_valid and timeout are single-cycle strobes with no
// back-pressure; the consumer must capture pulse_width on the pulse_valid
// cycle (it is also held until the next valid). At most one of the two
// strobes fires per measurement period, and never both in one cycle.
// ---------------------------------------------------------------------------
module ultrasonic_echo_capture #(
  parameter int TRIG_CYCLES    = 120,
  parameter int TIMEOUT_CYCLES = 360000,
  parameter int PERIOD_CYCLES  = 720000,
  parameter int WIDTH          = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             echo,
  output logic             trig,
  output logic [WIDTH-1:0] pulse_width,
  output logic             pulse_valid,
  output logic             timeout,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int CYC_W = $clog2(PERIOD_CYCLES);

  localparam logic [CYC_W-1:0] TRIG_LAST   = CYC_W'(TRIG_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_CYC = CYC_W'(TIMEOUT_CYCLES);
  localparam logic [CYC_W-1:0] PERIOD_LAST = CYC_W'(PERIOD_CYCLES - 1);
  localparam logic [WIDTH-1:0] WIDTH_MAX   = '1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

  state_e            state_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [CYC_W-1:0]  cyc_d;
  logic [WIDTH-1:0]  width_cnt_q;
  logic [WIDTH-1:0]  width_cnt_d;
  logic              echo_s1_q;
  logic              echo_s_q;
  logic              echo_d_q;
  logic              echo_rise;
  logic              at_timeout;
  logic              trig_q;
  logic [WIDTH-1:0]  pulse_width_q;
  logic              pulse_valid_q;
  logic              timeout_q;
  logic              busy_q;

  // Next-value helpers used by the FSM below.
  assign cyc_d       = cyc_q + CYC_W'(1);
  // Saturate so an absurdly long echo can never wrap to a short width.
  assign width_cnt_d = (width_cnt_q == WIDTH_MAX) ? width_cnt_q
                                                  : width_cnt_q + WIDTH'(1);
  // Edge detect on the synchronised echo: a level already high when the
  // measurement window opens never produces a rise.
  assign echo_rise   = echo_s_q & ~echo_d_q;
  assign at_timeout  = (cyc_q == TIMEOUT_CYC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cyc_q         <= '0;
      width_cnt_q   <= '0;
      echo_s1_q     <= 1'b0;
      echo_s_q      <= 1'b0;
      echo_d_q      <= 1'b0;
      trig_q        <= 1'b0;
      pulse_width_q <= '0;
      pulse_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      echo_s1_q     <= echo;
      echo_s_q      <= echo_s1_q;
      echo_d_q      <= echo_s_q;
      // Strobes default low; they are raised for exactly one cycle below.
      pulse_valid_q <= 1'b0;
      timeout_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          trig_q <= 1'b0;
          cyc_q  <= '0;
          if (enable) begin
            state_q <= ST_TRIG;
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        ST_TRIG: begin
          cyc_q <= cyc_d;
          if (cyc_q == TRIG_LAST) begin
            state_q <= ST_WAIT_RISE;
            trig_q  <= 1'b0;
          end
        end

        ST_WAIT_RISE: begin
          cyc_q <= cyc_d;
          if (at_timeout) begin
            timeout_q <= 1'b1;
            state_q   <= ST_HOLDOFF;
          end else if (echo_rise) begin
            // The rise cycle itself is the first high cycle of the echo.
            width_cnt_q <= WIDTH'(1);
            state_q     <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          cyc_q <= cyc_d;
          // A fall seen on the timeout cycle still completes the echo, so the
          // valid path is checked first.
          if (!echo_s_q) begin
            pulse_width_q <= width_cnt_q;
            pulse_valid_q <= 1'b1;
            state_q       <= ST_HOLDOFF;
          end else if (at_timeout) begin
            timeout_q <= 1'b1;
            state_q   <= ST_HOLDOFF;
          end else begin
            width_cnt_q <= width_cnt_d;
          end
        end

        ST_HOLDOFF: begin
          trig_q <= 1'b0;
          if (cyc_q == PERIOD_LAST) begin
            cyc_q <= '0;
            if (enable) begin
              state_q <= ST_TRIG;
              trig_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cyc_q <= cyc_d;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          trig_q  <= 1'b0;
          busy_q  <= 1'b0;
          cyc_q   <= '0;
        end
      endcase
    end
  end

  assign trig        = trig_q;
  assign pulse_width = pulse_width_q;
  assign pulse_valid = pulse_valid_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/ultrasonic_echo_capture.md
# ultrasonic_echo_capture

Front-end timing stage for the HC-SR04-style ultrasonic ranger. It generates the periodic trigger pulse, synchronises the asynchronous echo pin, and measures the echo high time in clock cycles. It hands a cycle-accurate width plus a one-cycle valid strobe (or a timeout strobe) to the downstream distance-conversion and buzzer logic. All arithmetic is in raw clock cycles; cm conversion happens downstream.

## Interface
- TRIG_CYCLES, 120: trig high time in clk cycles (10 µs at 12 MHz).
- TIMEOUT_CYCLES, 360000: max cycles from first trig cycle to echo fall (30 ms).
- PERIOD_CYCLES, 720000: measurement repetition period (60 ms); must exceed TIMEOUT_CYCLES.
- WIDTH, 20: pulse_width width; must satisfy 2^WIDTH-1 ≥ TIMEOUT_CYCLES.
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  run continuous measurements while high.
- echo  in  1  raw sensor echo pin; asynchronous.
- trig  out  1  sensor trigger pulse, registered.
- pulse_width  out  WIDTH  last measured echo high time in cycles; held until next valid.
- pulse_valid  out  1  one-cycle strobe: pulse_width updated.
- timeout  out  1  one-cycle strobe: no complete echo within TIMEOUT_CYCLES.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset (reset=0, async): state IDLE; trig=0, pulse_width=0, pulse_valid=0, timeout=0, busy=0; sync flops and counters cleared.
- Echo sync: two flops give echo_s; a third gives echo_d; rise = echo_s & ~echo_d.
- Cycle counter cyc: set to 0 on the first TRIG cycle, then +1 every cycle until PERIOD_CYCLES-1. Width = ceil(log2(PERIOD_CYCLES)).
- IDLE: trig=0. If enable=1, go to TRIG next cycle.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
- WAIT_RISE: accept only a rise edge. A level already high on entry (stuck or late echo) is ignored until it falls and rises again. On rise: width_cnt=1, go to MEASURE.
- MEASURE: each cycle with echo_s=1, width_cnt+1, saturating at 2^WIDTH-1. First cycle with echo_s=0: pulse_width=width_cnt, pulse_valid=1 for one cycle, go to HOLDOFF.
- Timeout: in WAIT_RISE or MEASURE, when cyc == TIMEOUT_CYCLES: timeout=1 for one cycle, pulse_width unchanged, go to HOLDOFF.
- Same-cycle echo fall and timeout: the valid path wins; no timeout is reported.
- HOLDOFF: trig=0. When cyc == PERIOD_CYCLES-1: if enable=1 go to TRIG (cyc restarts at 0), else go to IDLE.
- enable is sampled only in IDLE and at the end of HOLDOFF. Deasserting it mid-cycle lets the current measurement finish, and valid or timeout is still reported.
- pulse_valid and timeout are never high in the same cycle. Each appears at most once per period.

## Timing
- Trigger period is exactly PERIOD_CYCLES while enable stays high. trig rises on cyc=0 and falls after cyc=TRIG_CYCLES-1.
- IDLE to trig high: 1 cycle after enable is sampled high.
- Echo latency: a clean echo pin high for N cycles gives pulse_width=N. pulse_valid asserts 3 clk edges after the pin falls (2 sync + 1 register).
- Timeout strobe occurs in the cycle after cyc reaches TIMEOUT_CYCLES.
- All outputs are registered; no combinational path from echo to any output.

## Test plan
Use TRIG_CYCLES=4, TIMEOUT_CYCLES=40, PERIOD_CYCLES=64, WIDTH=8.
- Release reset with enable=1 and echo=0 -> trig high exactly 4 cycles, rising every 64 cycles; timeout strobe once per period; pulse_valid never asserts.
- Echo pin high for 20 cycles, starting 6 cycles after trig falls -> pulse_width=20, pulse_valid for one cycle, 3 cycles after echo falls; no timeout that period.
- Echo held high from before trig through the whole period -> no pulse_valid; timeout strobe at cyc 40; pulse_width keeps its previous value.
- Echo rises at cyc 10 and stays high past cyc 40 -> timeout at cyc 40, no valid. Echo falling at exactly the timeout cycle -> valid reported, no timeout.
- Drop enable during MEASURE with an 8-cycle echo -> pulse_width=8 with valid; state goes to IDLE at cyc 63; trig stays low and busy=0 afterwards.
- Assert reset mid-MEASURE -> trig, busy and pulse_width are 0 immediately, with no strobes. On release with enable=1, the next trig comes 1 cycle after IDLE samples enable.
